// File: rtl/axi_ar_burst_split.sv
// Read-address splitter: cuts INCR bursts at MAX_LEN beats and 4 KB boundaries,
// then merges the R beats back so that upstream sees one RLAST per AR.
module axi_ar_burst_split #(
    parameter int unsigned AW        = 64,
    parameter int unsigned IW        = 12,
    parameter int unsigned DW        = 64,
    parameter int unsigned MAX_LEN   = 16,
    parameter int unsigned TAG_DEPTH = 8
) (
    input  logic          m_axi_aclk,
    input  logic          m_axi_aresetn,
    input  logic          s_arvalid,
    output logic          s_arready,
    input  logic [IW-1:0] s_arid,
    input  logic [AW-1:0] s_araddr,
    input  logic [7:0]    s_arlen,
    input  logic [2:0]    s_arsize,
    input  logic [1:0]    s_arburst,
    input  logic [3:0]    s_arcache,
    input  logic [2:0]    s_arprot,
    output logic          m_arvalid,
    input  logic          m_arready,
    output logic [IW-1:0] m_arid,
    output logic [AW-1:0] m_araddr,
    output logic [7:0]    m_arlen,
    output logic [2:0]    m_arsize,
    output logic [1:0]    m_arburst,
    output logic [3:0]    m_arcache,
    output logic [2:0]    m_arprot,
    input  logic          m_rvalid,
    output logic          m_rready,
    input  logic [IW-1:0] m_rid,
    input  logic [DW-1:0] m_rdata,
    input  logic [1:0]    m_rresp,
    input  logic          m_rlast,
    output logic          s_rvalid,
    input  logic          s_rready,
    output logic [IW-1:0] s_rid,
    output logic [DW-1:0] s_rdata,
    output logic [1:0]    s_rresp,
    output logic          s_rlast
);

    localparam int unsigned PW = $clog2(TAG_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [1:0]  BURST_INCR = 2'b01;

    typedef enum logic {IDLE, SPLIT} state_t;

    state_t          state_q, state_n;
    logic            s_arready_q, s_arready_n;
    logic            m_arvalid_q, m_arvalid_n;
    logic [IW-1:0]   id_q, id_n;
    logic [AW-1:0]   addr_q, addr_n;
    logic [7:0]      len_q, len_n;
    logic [2:0]      size_q, size_n;
    logic [1:0]      burst_q, burst_n;
    logic [3:0]      cache_q, cache_n;
    logic [2:0]      prot_q, prot_n;
    logic [8:0]      rem_q, rem_n;

    logic            tag_mem [TAG_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_n;

    logic            push, pop, tag_empty;
    logic [8:0]      hs_beats, rem_after;
    logic [AW-1:0]   addr_after;

    // Beats that fit in one sub-burst; only INCR is ever cut.
    function automatic logic [8:0] calc_beats(input logic [11:0] off, input logic [8:0] rem,
                                              input logic [2:0] size, input logic [1:0] burst);
        logic [11:0] lo_mask;
        logic [12:0] b4k;
        logic [12:0] beats;
        lo_mask = ~(12'hFFF << size);
        b4k     = (13'd4096 - {1'b0, off & ~lo_mask}) >> size;
        beats   = {4'd0, rem};
        if (burst == BURST_INCR) begin
            if (13'(MAX_LEN) < beats) beats = 13'(MAX_LEN);
            if (b4k < beats)          beats = b4k;
        end
        return beats[8:0];
    endfunction

    assign tag_empty  = (count_q == '0);
    assign push       = m_arvalid_q & m_arready;
    assign pop        = m_rvalid & s_rready & m_rlast & ~tag_empty;
    assign count_n    = count_q + CW'(push) - CW'(pop);
    assign hs_beats   = 9'(len_q) + 9'd1;
    assign rem_after  = rem_q - hs_beats;
    assign addr_after = (addr_q & ~((AW'(1) << size_q) - AW'(1))) + (AW'(hs_beats) << size_q);

    // Next-state and next-output logic for the AR side.
    always_comb begin
        state_n     = state_q;
        s_arready_n = s_arready_q;
        m_arvalid_n = m_arvalid_q;
        id_n        = id_q;
        addr_n      = addr_q;
        len_n       = len_q;
        size_n      = size_q;
        burst_n     = burst_q;
        cache_n     = cache_q;
        prot_n      = prot_q;
        rem_n       = rem_q;
        case (state_q)
            IDLE: begin
                s_arready_n = 1'b1;
                m_arvalid_n = 1'b0;
                if (s_arvalid && s_arready_q) begin
                    id_n        = s_arid;
                    size_n      = s_arsize;
                    burst_n     = s_arburst;
                    cache_n     = s_arcache;
                    prot_n      = s_arprot;
                    addr_n      = s_araddr;
                    rem_n       = 9'(s_arlen) + 9'd1;
                    len_n       = 8'(calc_beats(s_araddr[11:0], 9'(s_arlen) + 9'd1,
                                                s_arsize, s_arburst) - 9'd1);
                    s_arready_n = 1'b0;
                    m_arvalid_n = (count_n < CW'(TAG_DEPTH));
                    state_n     = SPLIT;
                end
            end
            SPLIT: begin
                s_arready_n = 1'b0;
                m_arvalid_n = (count_n < CW'(TAG_DEPTH));
                if (push) begin
                    rem_n  = rem_after;
                    addr_n = addr_after;
                    if (rem_after == 9'd0) begin
                        state_n     = IDLE;
                        s_arready_n = 1'b1;
                        m_arvalid_n = 1'b0;
                    end else begin
                        len_n = 8'(calc_beats(addr_after[11:0], rem_after, size_q, burst_q) - 9'd1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q     <= IDLE;
            s_arready_q <= 1'b0;
            m_arvalid_q <= 1'b0;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            cache_q     <= '0;
            prot_q      <= '0;
            rem_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_n;
            s_arready_q <= s_arready_n;
            m_arvalid_q <= m_arvalid_n;
            id_q        <= id_n;
            addr_q      <= addr_n;
            len_q       <= len_n;
            size_q      <= size_n;
            burst_q     <= burst_n;
            cache_q     <= cache_n;
            prot_q      <= prot_n;
            rem_q       <= rem_n;
            count_q     <= count_n;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // Tag = this sub-burst carries the upstream burst's final beat.
    always_ff @(posedge m_axi_aclk) begin
        if (push) tag_mem[wr_ptr_q] <= (rem_q == hs_beats);
    end

    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_aresetn && m_rvalid) begin
            a_r_without_tag: assert (!tag_empty);
        end
    end

    assign s_arready = s_arready_q;
    assign m_arvalid = m_arvalid_q;
    assign m_arid    = id_q;
    assign m_araddr  = addr_q;
    assign m_arlen   = len_q;
    assign m_arsize  = size_q;
    assign m_arburst = burst_q;
    assign m_arcache = cache_q;
    assign m_arprot  = prot_q;

    assign s_rvalid  = m_rvalid;
    assign m_rready  = s_rready;
    assign s_rid     = m_rid;
    assign s_rdata   = m_rdata;
    assign s_rresp   = m_rresp;
    assign s_rlast   = m_rlast & tag_mem[rd_ptr_q] & ~tag_empty;

endmodule

// File: tb/tb_axi_ar_burst_split.sv
// Directed bench for axi_ar_burst_split: split points, tag gating, RLAST merge, reset.
module tb_axi_ar_burst_split;

    localparam int unsigned AW = 64;
    localparam int unsigned IW = 12;
    localparam int unsigned DW = 64;
    localparam logic [1:0] INCR = 2'b01;
    localparam logic [1:0] WRAP = 2'b10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_arvalid, s_arready;
    logic [IW-1:0] s_arid;
    logic [AW-1:0] s_araddr;
    logic [7:0]    s_arlen;
    logic [2:0]    s_arsize;
    logic [1:0]    s_arburst;
    logic [3:0]    s_arcache;
    logic [2:0]    s_arprot;
    logic          m_arvalid, m_arready;
    logic [IW-1:0] m_arid;
    logic [AW-1:0] m_araddr;
    logic [7:0]    m_arlen;
    logic [2:0]    m_arsize;
    logic [1:0]    m_arburst;
    logic [3:0]    m_arcache;
    logic [2:0]    m_arprot;
    logic          m_rvalid, m_rready;
    logic [IW-1:0] m_rid;
    logic [DW-1:0] m_rdata;
    logic [1:0]    m_rresp;
    logic          m_rlast;
    logic          s_rvalid, s_rready;
    logic [IW-1:0] s_rid;
    logic [DW-1:0] s_rdata;
    logic [1:0]    s_rresp;
    logic          s_rlast;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int served = 0;

    logic [AW-1:0] ar_addr_q [$];
    logic [7:0]    ar_len_q  [$];
    int            ar_cyc_q  [$];
    int            rlast_q   [$];
    int            beat_cnt = 0;
    int            mlast_cnt = 0;
    int            pass_err = 0;
    int            slverr_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axi_ar_burst_split #(.AW(AW), .IW(IW), .DW(DW), .MAX_LEN(16), .TAG_DEPTH(8)) dut (
        .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arcache(s_arcache),
        .s_arprot(s_arprot),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
        .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arcache(m_arcache),
        .m_arprot(m_arprot),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata),
        .m_rresp(m_rresp), .m_rlast(m_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
        .s_rresp(s_rresp), .s_rlast(s_rlast)
    );

    // Handshakes complete at the next rising edge; inputs and outputs are stable here.
    always @(negedge clk) begin
        if (rst_n && m_arvalid && m_arready) begin
            ar_addr_q.push_back(m_araddr);
            ar_len_q.push_back(m_arlen);
            ar_cyc_q.push_back(cyc);
        end
        if (rst_n && s_rvalid && s_rready) begin
            beat_cnt++;
            if (s_rlast) rlast_q.push_back(beat_cnt);
            if (s_rdata !== m_rdata || s_rid !== m_rid || s_rresp !== m_rresp) pass_err++;
            if (s_rresp == 2'b10) slverr_cnt++;
        end
        if (rst_n && m_rvalid && m_rready && m_rlast) mlast_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_ar(input logic [AW-1:0] a, input logic [7:0] len, input logic [2:0] sz,
                           input logic [1:0] bu, output int hs_cyc);
        s_arvalid = 1'b1; s_araddr = a; s_arlen = len; s_arsize = sz; s_arburst = bu;
        s_arid = 12'h5A3; s_arcache = 4'h3; s_arprot = 3'h2;
        hs_cyc = -1;
        for (int i = 0; i < 200; i++) begin
            if (s_arready) begin
                hs_cyc = cyc;
                break;
            end
            tick(1);
        end
        checks++;
        if (hs_cyc < 0) begin
            failures++;
            $display("FAIL s_ar_handshake: s_arready never seen, required 1");
        end
        tick(1);
        s_arvalid = 1'b0;
    endtask

    task automatic serve(input int n);
        for (int b = 0; b < n; b++) begin
            int t = 0;
            int len;
            while (served >= ar_len_q.size() && t < 300) begin
                tick(1);
                t++;
            end
            checks++;
            if (served >= ar_len_q.size()) begin
                failures++;
                $display("FAIL serve_wait: downstream AR %0d never issued, required issue", served);
                return;
            end
            len = int'(ar_len_q[served]);
            served++;
            for (int j = 0; j <= len; j++) begin
                m_rvalid = 1'b1;
                m_rid    = 12'h5A3;
                m_rdata  = DW'(j) ^ 64'hA5A5_0000_F0F0_1234;
                m_rresp  = (j == 2) ? 2'b10 : 2'b00;
                m_rlast  = (j == len);
                tick(1);
            end
            m_rvalid = 1'b0;
            m_rlast  = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s_arvalid = 1'b0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
        s_arid = '0; s_arcache = '0; s_arprot = '0;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0;
        m_rlast = 1'b0; s_rready = 1'b1;
        tick(3);
        checks++;
        if (s_arready !== 1'b0 || m_arvalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid_ready: s_arready=%b m_arvalid=%b, required 0/0", s_arready, m_arvalid);
        end
        checks++;
        if (m_araddr !== '0 || m_arlen !== '0 || m_arid !== '0 || s_rlast !== 1'b0) begin
            failures++;
            $display("FAIL reset_fields: m_araddr=%h m_arlen=%0d m_arid=%h s_rlast=%b, required 0",
                     m_araddr, m_arlen, m_arid, s_rlast);
        end
        #2 rst_n = 1'b1;
        tick(1);
        checks++;
        if (s_arready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: s_arready=%b, required 1", s_arready);
        end
    endtask

    task automatic test_single();
        int hs, ab, rb, bb;
        ab = ar_addr_q.size(); rb = rlast_q.size(); bb = beat_cnt;
        m_arready = 1'b0;
        send_ar(64'h0, 8'd7, 3'd3, INCR, hs);
        checks++;
        if (m_arvalid !== 1'b1 || m_arid !== 12'h5A3 || m_arsize !== 3'd3 || m_arburst !== INCR ||
            m_arcache !== 4'h3 || m_arprot !== 3'h2) begin
            failures++;
            $display("FAIL single_fields: valid=%b id=%h size=%0d burst=%0d cache=%h prot=%h, required 1/5a3/3/1/3/2",
                     m_arvalid, m_arid, m_arsize, m_arburst, m_arcache, m_arprot);
        end
        m_arready = 1'b1;
        tick(3);
        checks++;
        if (ar_addr_q.size() != ab + 1 || ar_addr_q[ab] !== 64'h0 || ar_len_q[ab] !== 8'd7) begin
            failures++;
            $display("FAIL single_ar: count=%0d, required 1 AR at 0x0 len 7", ar_addr_q.size() - ab);
        end
        serve(1);
        checks++;
        if (rlast_q.size() != rb + 1 || rlast_q[rb] != bb + 8) begin
            failures++;
            $display("FAIL single_rlast: rlast count=%0d, required 1 on beat 8", rlast_q.size() - rb);
        end
        checks++;
        if (pass_err != 0 || slverr_cnt != 1) begin
            failures++;
            $display("FAIL single_r_passthru: mismatched beats=%0d slverr=%0d, required 0/1", pass_err, slverr_cnt);
        end
    endtask

    task automatic test_max_len();
        int hs, ab, rb, bb, mb;
        logic [AW-1:0] exp_a;
        ab = ar_addr_q.size(); rb = rlast_q.size(); bb = beat_cnt; mb = mlast_cnt;
        m_arready = 1'b1;
        send_ar(64'h0, 8'd63, 3'd3, INCR, hs);
        tick(6);
        checks++;
        if (ar_addr_q.size() != ab + 4) begin
            failures++;
            $display("FAIL maxlen_count: ARs=%0d, required 4", ar_addr_q.size() - ab);
        end else begin
            for (int i = 0; i < 4; i++) begin
                exp_a = AW'(i * 128);
                checks++;
                if (ar_addr_q[ab+i] !== exp_a || ar_len_q[ab+i] !== 8'd15 ||
                    ar_cyc_q[ab+i] != hs + 1 + i) begin
                    failures++;
                    $display("FAIL maxlen_ar%0d: addr=%h len=%0d cyc=%0d, required %h/15/%0d",
                             i, ar_addr_q[ab+i], ar_len_q[ab+i], ar_cyc_q[ab+i], exp_a, hs + 1 + i);
                end
            end
        end
        serve(4);
        checks++;
        if (rlast_q.size() != rb + 1 || rlast_q[rb] != bb + 64 || mlast_cnt != mb + 4) begin
            failures++;
            $display("FAIL maxlen_rlast: s_rlast=%0d m_rlast=%0d, required 1 (beat 64) and 4",
                     rlast_q.size() - rb, mlast_cnt - mb);
        end
    endtask

    task automatic test_4k_cross();
        int hs, ab, rb, bb;
        ab = ar_addr_q.size(); rb = rlast_q.size(); bb = beat_cnt;
        send_ar(64'h0FC0, 8'd15, 3'd3, INCR, hs);
        tick(4);
        checks++;
        if (ar_addr_q.size() != ab + 2 || ar_addr_q[ab] !== 64'h0FC0 || ar_len_q[ab] !== 8'd7 ||
            ar_addr_q[ab+1] !== 64'h1000 || ar_len_q[ab+1] !== 8'd7) begin
            failures++;
            $display("FAIL cross4k_ar: count=%0d, required (0fc0,7),(1000,7)", ar_addr_q.size() - ab);
        end
        serve(2);
        checks++;
        if (rlast_q.size() != rb + 1 || rlast_q[rb] != bb + 16) begin
            failures++;
            $display("FAIL cross4k_rlast: count=%0d, required 1 on beat 16", rlast_q.size() - rb);
        end
    endtask

    task automatic test_unaligned_wrap();
        int hs, ab, rb, bb;
        ab = ar_addr_q.size(); rb = rlast_q.size(); bb = beat_cnt;
        send_ar(64'h0FFC, 8'd1, 3'd3, INCR, hs);
        send_ar(64'h0FF0, 8'd3, 3'd3, WRAP, hs);
        tick(4);
        checks++;
        if (ar_addr_q.size() != ab + 3 || ar_addr_q[ab] !== 64'h0FFC || ar_len_q[ab] !== 8'd0 ||
            ar_addr_q[ab+1] !== 64'h1000 || ar_len_q[ab+1] !== 8'd0) begin
            failures++;
            $display("FAIL unaligned_ar: count=%0d, required (0ffc,0),(1000,0)", ar_addr_q.size() - ab);
        end
        checks++;
        if (ar_addr_q.size() != ab + 3 || ar_addr_q[ab+2] !== 64'h0FF0 || ar_len_q[ab+2] !== 8'd3) begin
            failures++;
            $display("FAIL wrap_ar: count=%0d, required third AR (0ff0,3)", ar_addr_q.size() - ab);
        end
        serve(3);
        checks++;
        if (rlast_q.size() != rb + 2 || rlast_q[rb] != bb + 2 || rlast_q[rb+1] != bb + 6) begin
            failures++;
            $display("FAIL unaligned_rlast: count=%0d, required 2 on beats 2 and 6", rlast_q.size() - rb);
        end
    endtask

    task automatic test_tag_full();
        int hs, ab, rb, bb;
        ab = ar_addr_q.size(); rb = rlast_q.size(); bb = beat_cnt;
        send_ar(64'h0, 8'd255, 3'd3, INCR, hs);
        tick(20);
        checks++;
        if (ar_addr_q.size() != ab + 8 || m_arvalid !== 1'b0) begin
            failures++;
            $display("FAIL tagfull_gate: ARs=%0d m_arvalid=%b, required 8/0", ar_addr_q.size() - ab, m_arvalid);
        end
        serve(1);
        tick(3);
        checks++;
        if (ar_addr_q.size() != ab + 9 || m_arvalid !== 1'b0) begin
            failures++;
            $display("FAIL tagfull_release: ARs=%0d m_arvalid=%b, required 9/0", ar_addr_q.size() - ab, m_arvalid);
        end
        serve(15);
        tick(2);
        checks++;
        if (ar_addr_q.size() != ab + 16 || ar_addr_q[ar_addr_q.size()-1] !== 64'h780 ||
            ar_len_q[ar_len_q.size()-1] !== 8'd15) begin
            failures++;
            $display("FAIL tagfull_total: ARs=%0d, required 16 ending at (780,15)", ar_addr_q.size() - ab);
        end
        checks++;
        if (rlast_q.size() != rb + 1 || rlast_q[rb] != bb + 256 || s_arready !== 1'b1) begin
            failures++;
            $display("FAIL tagfull_rlast: count=%0d s_arready=%b, required 1 on beat 256 and ready 1",
                     rlast_q.size() - rb, s_arready);
        end
    endtask

    task automatic test_reset_mid_split();
        int hs, ab, rb, bb;
        ab = ar_addr_q.size();
        m_arready = 1'b0;
        send_ar(64'h0, 8'd63, 3'd3, INCR, hs);
        m_arready = 1'b1;
        tick(2);
        m_arready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (m_arvalid !== 1'b0 || s_arready !== 1'b0 || ar_addr_q.size() != ab + 2) begin
            failures++;
            $display("FAIL midreset_async: m_arvalid=%b s_arready=%b ARs=%0d, required 0/0/2",
                     m_arvalid, s_arready, ar_addr_q.size() - ab);
        end
        served = ar_addr_q.size();
        tick(1);
        rst_n = 1'b1;
        tick(1);
        checks++;
        if (s_arready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_ready: s_arready=%b, required 1", s_arready);
        end
        ab = ar_addr_q.size(); rb = rlast_q.size(); bb = beat_cnt;
        m_arready = 1'b1;
        send_ar(64'h2000, 8'd3, 3'd3, INCR, hs);
        tick(4);
        checks++;
        if (ar_addr_q.size() != ab + 1 || ar_addr_q[ab] !== 64'h2000 || ar_len_q[ab] !== 8'd3) begin
            failures++;
            $display("FAIL midreset_new_ar: ARs=%0d, required 1 at (2000,3)", ar_addr_q.size() - ab);
        end
        serve(1);
        checks++;
        if (rlast_q.size() != rb + 1 || rlast_q[rb] != bb + 4) begin
            failures++;
            $display("FAIL midreset_rlast: count=%0d, required 1 on beat 4", rlast_q.size() - rb);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_max_len();
        test_4k_cross();
        test_unaligned_wrap();
        test_tag_full();
        test_reset_mid_split();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_ar_burst_split.md
Name: axi_ar_burst_split

Overview:
- Read-address splitter on the master side of the AXI data-width converter, in the m_axi_aclk domain.
- Takes converter output ARs. Each INCR burst is cut into sub-bursts that never cross a 4 KB boundary and never exceed MAX_LEN beats.
- R beats are passed back upstream. RLAST is suppressed on every sub-burst except the final one, so the upstream side sees exactly one burst per AR.
- Downstream must return R data in AR issue order (single-ID or in-order slave). Per-ID reordering is out of scope.

Parameters:
- AW, 64, address width.
- IW, 12, ID width.
- DW, 64, data width in bits (power of two, 32..1024).
- MAX_LEN, 16, maximum beats per downstream sub-burst (power of two, 1..256).
- TAG_DEPTH, 8, depth of the outstanding sub-burst tag FIFO (power of two, ≥2).

Ports:
- m_axi_aclk  in  1  clock.
- m_axi_aresetn  in  1  reset; one clock, asynchronous, active-low.
- s_arvalid / s_arready  in/out  1  upstream AR handshake.
- s_arid  in  IW  upstream AR ID.
- s_araddr  in  AW  upstream AR address.
- s_arlen  in  8  upstream burst length.
- s_arsize  in  3  upstream beat size.
- s_arburst  in  2  upstream burst type.
- s_arcache  in  4  passthrough.
- s_arprot  in  3  passthrough.
- m_arvalid / m_arready  out/in  1  downstream AR handshake.
- m_arid  out  IW  downstream AR ID.
- m_araddr  out  AW  downstream AR address.
- m_arlen  out  8  downstream burst length.
- m_arsize  out  3  downstream beat size.
- m_arburst  out  2  downstream burst type.
- m_arcache  out  4  passthrough.
- m_arprot  out  3  passthrough.
- m_rvalid / m_rready  in/out  1  downstream R handshake.
- m_rid  in  IW  downstream R ID.
- m_rdata  in  DW  downstream R data.
- m_rresp  in  2  downstream R response.
- m_rlast  in  1  downstream R last.
- s_rvalid / s_rready  out/in  1  upstream R handshake.
- s_rid  out  IW  upstream R ID.
- s_rdata  out  DW  upstream R data.
- s_rresp  out  2  upstream R response.
- s_rlast  out  1  upstream R last.

Behaviour:
- Reset (async assert, sync deassert by the clock edge):
  - s_arready=0, m_arvalid=0, all m_ar* registers 0.
  - FSM in IDLE, tag FIFO empty.
  - Asserting reset mid-split drops the in-flight transaction; no recovery of outstanding R beats.
- FSM IDLE:
  - s_arready=1.
  - On s_arvalid&s_arready, latch id/size/burst/cache/prot.
  - Latch cur_addr=s_araddr and remaining=s_arlen+1 (9-bit beat count).
  - Go to SPLIT. s_arready=0 the following cycle.
- FSM SPLIT: m_arvalid=1 whenever the tag FIFO is not full. m_ar* fields:
  - m_arid, m_arsize, m_arburst, m_arcache, m_arprot = latched values.
  - m_araddr = cur_addr.
  - INCR: beats = min(remaining, MAX_LEN, b4k), where b4k = (4096 − (cur_addr[11:0] & ~((1<<size)−1))) >> size. m_arlen = beats−1.
  - FIXED/WRAP: beats = remaining, never split.
- On m_arvalid&m_arready:
  - Push tag = (remaining==beats) into the FIFO.
  - remaining −= beats.
  - cur_addr = (cur_addr & ~((1<<size)−1)) + (beats<<size); unaligned start realigns after the first sub-burst.
  - If remaining becomes 0, go to IDLE.
- m_ar* is held stable while m_arvalid&!m_arready; the AXI stability rule applies.
- Latency and throughput:
  - First m_arvalid rises one cycle after the s_ar handshake.
  - One sub-burst per cycle under continuous m_arready.
  - One idle cycle (IDLE state) between consecutive upstream ARs.
- TAG_DEPTH gate: when the FIFO is full, m_arvalid deasserts. It reasserts the cycle after a pop frees a slot; m_ar* fields are unchanged.
- R path is purely combinational:
  - s_rvalid=m_rvalid, m_rready=s_rready.
  - s_rid/s_rdata/s_rresp pass straight through; every beat's rresp is forwarded.
  - s_rlast = m_rlast & tag_head.
  - Pop tag on m_rvalid&m_rready&m_rlast.
- Simultaneous push and pop on a full FIFO is allowed; occupancy is unchanged.
- m_rvalid with the FIFO empty is a protocol error. Flag it with a simulation assertion; s_rlast=0 in that case.

Test Plan:
- Single burst, DW=64: araddr 0x0000, arlen 7, arsize 3, INCR → one m_ar (0x0000, len 7); s_rlast only on beat 8.
- MAX_LEN split: araddr 0x0000, arlen 63, arsize 3 → four m_ar at 0x000/0x080/0x100/0x180, each len 15, issued on 4 consecutive cycles with m_arready=1; s_rlast only on beat 64; m_rlast seen 4 times.
- 4 KB cross: araddr 0x0FC0, arlen 15, arsize 3 → m_ar (0x0FC0, len 7), then (0x1000, len 7).
- Unaligned 4 KB cross: araddr 0x0FFC, arlen 1, arsize 3 → (0x0FFC, len 0), then (0x1000, len 0); WRAP araddr 0x0FF0, arlen 3 → single m_ar unchanged.
- Tag full: TAG_DEPTH 8, m_rvalid held 0, araddr 0, arlen 255, arsize 3 → 8 m_ar handshakes, then m_arvalid=0; each completed downstream burst releases one more m_ar; 16 total; single s_rlast on beat 256.
- Reset mid-split: assert m_axi_aresetn=0 after 2 of 4 sub-bursts → m_arvalid and s_arready go to 0 without waiting for a clock edge; after release, s_arready=1 on the first clock edge and a new AR (0x2000, len 3) issues unsplit.
